// File: rtl/dp_ctrl_pkg.sv
// Shared encodings for the register-file/ALU control sequencer:
// opcodes, extended opcodes, FSM states and flag bit positions.
package dp_ctrl_pkg;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ANDI  = 4'h1;
  localparam logic [3:0] OP_ORI   = 4'h2;
  localparam logic [3:0] OP_XORI  = 4'h3;
  localparam logic [3:0] OP_ADDI  = 4'h5;
  localparam logic [3:0] OP_SUBI  = 4'h9;
  localparam logic [3:0] OP_CMPI  = 4'hB;
  localparam logic [3:0] OP_MOVI  = 4'hD;

  localparam logic [3:0] EX_AND   = 4'h1;
  localparam logic [3:0] EX_OR    = 4'h2;
  localparam logic [3:0] EX_XOR   = 4'h3;
  localparam logic [3:0] EX_ADD   = 4'h5;
  localparam logic [3:0] EX_ADDC  = 4'h7;
  localparam logic [3:0] EX_SUB   = 4'h9;
  localparam logic [3:0] EX_CMP   = 4'hB;
  localparam logic [3:0] EX_MOV   = 4'hD;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_t;

  // flags are packed {C,L,F,Z,N}
  localparam int unsigned FLAG_C = 4;
  localparam int unsigned FLAG_L = 3;
  localparam int unsigned FLAG_F = 2;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 0;

endpackage

// File: rtl/dp_instr_decode.sv
// Combinational instruction decoder: ALU op/exop, extended immediate,
// carry-in and writeback/illegal classification for one instruction word.
module dp_instr_decode
  import dp_ctrl_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [15:0]   instr,
  input  logic          carry,
  output logic [3:0]    op,
  output logic [3:0]    exop,
  output logic [DW-1:0] immediate,
  output logic          regOrImmed,
  output logic          Cin,
  output logic          is_rtype,
  output logic          no_wb,
  output logic          illegal
);

  logic [3:0]    opc;
  logic [3:0]    ex;
  logic [7:0]    imm8;
  logic [DW-1:0] imm_sext;
  logic [DW-1:0] imm_zext;
  logic          unused_rdest;

  assign opc          = instr[15:12];
  assign ex           = instr[7:4];
  assign imm8         = instr[7:0];
  assign imm_sext     = {{(DW-8){imm8[7]}}, imm8};
  assign imm_zext     = {{(DW-8){1'b0}}, imm8};
  assign unused_rdest = ^instr[11:8];

  // Illegal encodings leave every ALU control at zero.
  always_comb begin
    op         = '0;
    exop       = '0;
    immediate  = '0;
    regOrImmed = 1'b0;
    Cin        = 1'b0;
    is_rtype   = 1'b0;
    no_wb      = 1'b0;
    illegal    = 1'b0;
    if (opc == OP_RTYPE) begin
      is_rtype = 1'b1;
      case (ex)
        EX_ADD, EX_AND, EX_OR, EX_XOR, EX_MOV: exop = ex;
        EX_ADDC: begin
          exop = ex;
          Cin  = carry;
        end
        EX_SUB: begin
          exop = ex;
          Cin  = 1'b1;
        end
        EX_CMP: begin
          exop  = ex;
          Cin   = 1'b1;
          no_wb = 1'b1;
        end
        default: illegal = 1'b1;
      endcase
    end else begin
      case (opc)
        OP_ADDI, OP_MOVI: begin
          op         = opc;
          immediate  = imm_sext;
          regOrImmed = 1'b1;
        end
        OP_SUBI: begin
          op         = opc;
          immediate  = imm_sext;
          regOrImmed = 1'b1;
          Cin        = 1'b1;
        end
        OP_CMPI: begin
          op         = opc;
          immediate  = imm_sext;
          regOrImmed = 1'b1;
          Cin        = 1'b1;
          no_wb      = 1'b1;
        end
        OP_ANDI, OP_ORI, OP_XORI: begin
          op         = opc;
          immediate  = imm_zext;
          regOrImmed = 1'b1;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/dp_sequencer.sv
// Multi-cycle control sequencer: accepts one instruction, walks
// DECODE -> EXEC -> WB with registered datapath controls and flag register.
module dp_sequencer
  import dp_ctrl_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int DW    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [4:0]       alu_flags,
  output logic [DW-1:0]    immediate,
  output logic [NREGS-1:0] regEnables,
  output logic [NREGS-1:0] buffAEnables,
  output logic [NREGS-1:0] buffBEnables,
  output logic             Cin,
  output logic             regOrImmed,
  output logic [3:0]       op,
  output logic [3:0]       exop,
  output logic [4:0]       flags,
  output logic             illegal,
  output logic             busy
);

  state_t state;
  state_t next_state;

  logic [3:0]    rdest_q;
  logic          wb_en_q;
  logic          illegal_q;
  logic          accept;

  logic [3:0]    dec_op;
  logic [3:0]    dec_exop;
  logic [DW-1:0] dec_imm;
  logic          dec_roi;
  logic          dec_cin;
  logic          dec_is_rtype;
  logic          dec_no_wb;
  logic          dec_illegal;

  logic [DW-1:0]    imm_d;
  logic [NREGS-1:0] reg_en_d;
  logic [NREGS-1:0] buff_a_d;
  logic [NREGS-1:0] buff_b_d;
  logic             cin_d;
  logic             roi_d;
  logic [3:0]       op_d;
  logic [3:0]       exop_d;
  logic             illegal_d;
  logic             busy_d;
  logic             ready_d;

  function automatic logic [NREGS-1:0] onehot(input logic [3:0] idx);
    onehot = NREGS'(1) << idx;
  endfunction

  dp_instr_decode #(
    .DW (DW)
  ) u_decode (
    .instr      (instr),
    .carry      (flags[FLAG_C]),
    .op         (dec_op),
    .exop       (dec_exop),
    .immediate  (dec_imm),
    .regOrImmed (dec_roi),
    .Cin        (dec_cin),
    .is_rtype   (dec_is_rtype),
    .no_wb      (dec_no_wb),
    .illegal    (dec_illegal)
  );

  assign accept = (state == ST_IDLE) && instr_valid && instr_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (accept) next_state = ST_DECODE;
      ST_DECODE: next_state = ST_EXEC;
      ST_EXEC:   next_state = ST_WB;
      ST_WB:     next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Controls are decoded from the live instr word on the accept edge so they
  // are already registered in DECODE, then held until WB retires.
  always_comb begin
    imm_d     = '0;
    reg_en_d  = '0;
    buff_a_d  = '0;
    buff_b_d  = '0;
    cin_d     = 1'b0;
    roi_d     = 1'b0;
    op_d      = '0;
    exop_d    = '0;
    illegal_d = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          imm_d     = dec_imm;
          cin_d     = dec_cin;
          roi_d     = dec_roi;
          op_d      = dec_op;
          exop_d    = dec_exop;
          illegal_d = dec_illegal;
          if (!dec_illegal) begin
            buff_a_d = onehot(instr[11:8]);
            if (dec_is_rtype) buff_b_d = onehot(instr[3:0]);
          end
        end
      end
      ST_DECODE, ST_EXEC: begin
        imm_d    = immediate;
        buff_a_d = buffAEnables;
        buff_b_d = buffBEnables;
        cin_d    = Cin;
        roi_d    = regOrImmed;
        op_d     = op;
        exop_d   = exop;
        if ((state == ST_EXEC) && wb_en_q) reg_en_d = onehot(rdest_q);
      end
      default: ;
    endcase
    busy_d  = (next_state != ST_IDLE);
    ready_d = (next_state == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      immediate    <= '0;
      regEnables   <= '0;
      buffAEnables <= '0;
      buffBEnables <= '0;
      Cin          <= 1'b0;
      regOrImmed   <= 1'b0;
      op           <= '0;
      exop         <= '0;
      illegal      <= 1'b0;
      busy         <= 1'b0;
      instr_ready  <= 1'b0;
      flags        <= '0;
      rdest_q      <= '0;
      wb_en_q      <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      immediate    <= imm_d;
      regEnables   <= reg_en_d;
      buffAEnables <= buff_a_d;
      buffBEnables <= buff_b_d;
      Cin          <= cin_d;
      regOrImmed   <= roi_d;
      op           <= op_d;
      exop         <= exop_d;
      illegal      <= illegal_d;
      busy         <= busy_d;
      instr_ready  <= ready_d;
      if (accept) begin
        rdest_q   <= instr[11:8];
        wb_en_q   <= !dec_no_wb && !dec_illegal;
        illegal_q <= dec_illegal;
      end
      if ((state == ST_EXEC) && !illegal_q) flags <= alu_flags;
    end
  end

endmodule

// File: tb/tb_dp_sequencer.sv
// Directed scoreboard bench for dp_sequencer: each issued instruction pushes
// its expected per-cycle output snapshots, popped and checked at each negedge.
module tb_dp_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [4:0]  alu_flags;
  logic [15:0] immediate;
  logic [15:0] regEnables;
  logic [15:0] buffAEnables;
  logic [15:0] buffBEnables;
  logic        Cin;
  logic        regOrImmed;
  logic [3:0]  op;
  logic [3:0]  exop;
  logic [4:0]  flags;
  logic        illegal;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [4:0] model_flags = '0;

  typedef struct {
    string       tag;
    logic [15:0] rege, bufa, bufb, imm;
    logic [3:0]  op, exop;
    logic        cin, roi, ill, busy, rdy;
    logic [4:0]  flg;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  dp_sequencer #(.NREGS(16), .DW(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .alu_flags    (alu_flags),
    .immediate    (immediate),
    .regEnables   (regEnables),
    .buffAEnables (buffAEnables),
    .buffBEnables (buffBEnables),
    .Cin          (Cin),
    .regOrImmed   (regOrImmed),
    .op           (op),
    .exop         (exop),
    .flags        (flags),
    .illegal      (illegal),
    .busy         (busy)
  );

  function automatic exp_t mk(input string tag, input logic [15:0] rege, bufa, bufb, imm,
                              input logic [3:0] op_e, exop_e, input logic cin, roi, ill,
                              busy_e, rdy, input logic [4:0] flg);
    exp_t e;
    e.tag = tag; e.rege = rege; e.bufa = bufa; e.bufb = bufb; e.imm = imm;
    e.op = op_e; e.exop = exop_e; e.cin = cin; e.roi = roi; e.ill = ill;
    e.busy = busy_e; e.rdy = rdy; e.flg = flg;
    return e;
  endfunction

  task automatic chk(input string tag, input string name, input logic [15:0] obs,
                     input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, name, obs, expv);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    chk(e.tag, "regEnables", regEnables,   e.rege);
    chk(e.tag, "buffA",      buffAEnables, e.bufa);
    chk(e.tag, "buffB",      buffBEnables, e.bufb);
    chk(e.tag, "immediate",  immediate,    e.imm);
    chk(e.tag, "op",         16'(op),      16'(e.op));
    chk(e.tag, "exop",       16'(exop),    16'(e.exop));
    chk(e.tag, "Cin",        16'(Cin),     16'(e.cin));
    chk(e.tag, "regOrImmed", 16'(regOrImmed), 16'(e.roi));
    chk(e.tag, "illegal",    16'(illegal), 16'(e.ill));
    chk(e.tag, "busy",       16'(busy),    16'(e.busy));
    chk(e.tag, "ready",      16'(instr_ready), 16'(e.rdy));
    chk(e.tag, "flags",      16'(flags),   16'(e.flg));
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (instr_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (instr_ready === 1'b1) else begin
      errors++;
      $error("FAIL %s.ready_timeout observed=%b expected=1", tag, instr_ready);
    end
  endtask

  task automatic run(input string tag, input logic [15:0] ins, input logic [4:0] af,
                     input logic [15:0] bufa, bufb, imm, input logic [3:0] op_e, exop_e,
                     input logic cin, roi, ill, input logic [15:0] rege, input bit hold);
    logic [4:0] nf;
    wait_ready(tag);
    instr = ins;
    instr_valid = 1'b1;
    alu_flags = af;
    nf = ill ? model_flags : af;
    sb.push_back(mk({tag, "/dec"}, '0, bufa, bufb, imm, op_e, exop_e, cin, roi, ill, 1'b1, 1'b0, model_flags));
    sb.push_back(mk({tag, "/exe"}, '0, bufa, bufb, imm, op_e, exop_e, cin, roi, 1'b0, 1'b1, 1'b0, model_flags));
    sb.push_back(mk({tag, "/wb"}, rege, bufa, bufb, imm, op_e, exop_e, cin, roi, 1'b0, 1'b1, 1'b0, nf));
    sb.push_back(mk({tag, "/idle"}, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, nf));
    model_flags = nf;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      pop_check();
      if (!hold || k == 3) instr_valid = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    instr = '0;
    instr_valid = 1'b0;
    alu_flags = '0;
    repeat (2) @(negedge clk);
    sb.push_back(mk("reset", '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b0));
    pop_check();
    reset = 1'b0;
    @(negedge clk);

    //   tag      instr    alu_flags  buffA    buffB    imm      op    exop  cin  roi  ill  regEn    hold
    run("add",    16'h0355, 5'b00001, 16'h0008, 16'h0020, 16'h0000, 4'h0, 4'h5, 1'b0, 1'b0, 1'b0, 16'h0008, 1'b0);
    run("addi",   16'h52FF, 5'b00010, 16'h0004, 16'h0000, 16'hFFFF, 4'h5, 4'h0, 1'b0, 1'b1, 1'b0, 16'h0004, 1'b0);
    run("andi",   16'h1180, 5'b00100, 16'h0002, 16'h0000, 16'h0080, 4'h1, 4'h0, 1'b0, 1'b1, 1'b0, 16'h0002, 1'b0);
    run("cmp",    16'h01B2, 5'b01010, 16'h0002, 16'h0004, 16'h0000, 4'h0, 4'hB, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    run("cmpi",   16'hB000, 5'b10000, 16'h0001, 16'h0000, 16'h0000, 4'hB, 4'h0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
    run("addc_c1",16'h0474, 5'b00000, 16'h0010, 16'h0010, 16'h0000, 4'h0, 4'h7, 1'b1, 1'b0, 1'b0, 16'h0010, 1'b0);
    run("addc_c0",16'h0474, 5'b00100, 16'h0010, 16'h0010, 16'h0000, 4'h0, 4'h7, 1'b0, 1'b0, 1'b0, 16'h0010, 1'b0);
    run("subi",   16'h9380, 5'b00011, 16'h0008, 16'h0000, 16'hFF80, 4'h9, 4'h0, 1'b1, 1'b1, 1'b0, 16'h0008, 1'b0);
    run("xori",   16'h3A80, 5'b00000, 16'h0400, 16'h0000, 16'h0080, 4'h3, 4'h0, 1'b0, 1'b1, 1'b0, 16'h0400, 1'b0);
    run("ill_op", 16'hF000, 5'b11111, 16'h0000, 16'h0000, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
    run("ill_ex", 16'h0540, 5'b10101, 16'h0000, 16'h0000, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
    run("mov_hold",16'h07D9,5'b01100, 16'h0080, 16'h0200, 16'h0000, 4'h0, 4'hD, 1'b0, 1'b0, 1'b0, 16'h0080, 1'b1);

    // valid was held through the busy period: nothing else may have started
    @(negedge clk);
    sb.push_back(mk("hold_after", '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, model_flags));
    pop_check();

    // reset while in EXEC discards the instruction
    wait_ready("rst_exec");
    instr = 16'h0355;
    instr_valid = 1'b1;
    alu_flags = 5'b11011;
    @(negedge clk);
    instr_valid = 1'b0;
    sb.push_back(mk("rst/dec", '0, 16'h0008, 16'h0020, '0, 4'h0, 4'h5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, model_flags));
    pop_check();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    model_flags = '0;
    sb.push_back(mk("rst/in", '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b0));
    pop_check();
    reset = 1'b0;
    @(negedge clk);
    sb.push_back(mk("rst/out1", '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b0));
    pop_check();
    @(negedge clk);
    sb.push_back(mk("rst/out2", '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b0));
    pop_check();

    run("post_rst",16'h0355, 5'b00110, 16'h0008, 16'h0020, 16'h0000, 4'h0, 4'h5, 1'b0, 1'b0, 1'b0, 16'h0008, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dp_sequencer.md
Name: dp_sequencer

Overview:
Multi-cycle control sequencer for the register-file/ALU datapath. It accepts one 16-bit instruction per handshake and decodes it into register-file write enables, tri-state read-buffer enables, ALU op/exop, carry-in and immediate/register select. It sequences DECODE -> EXEC -> WRITEBACK and holds the ALU flags register. It replaces the hard-coded control pattern generator that currently drives the datapath in simulation.

Parameters:
NREGS, 16, number of registers; width of all one-hot enable buses (index is instr nibble, NREGS <= 16)
DW, 16, datapath/immediate width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
instr  in  16  instruction word: [15:12] op, [11:8] rdest, [7:4] exop or imm_hi, [3:0] rsrc or imm_lo
instr_valid  in  1  instruction present
instr_ready  out  1  sequencer can accept (IDLE only)
alu_flags  in  5  ALU flag outputs {C,L,F,Z,N}
immediate  out  DW  extended immediate to ALU B mux
regEnables  out  NREGS  one-hot register write enable
buffAEnables  out  NREGS  one-hot read buffer, bus A
buffBEnables  out  NREGS  one-hot read buffer, bus B
Cin  out  1  ALU carry-in
regOrImmed  out  1  1 = ALU B from immediate, 0 = from bus B
op  out  4  ALU opcode
exop  out  4  ALU extended opcode
flags  out  5  registered {C,L,F,Z,N}
illegal  out  1  one-cycle pulse: undefined opcode accepted
busy  out  1  state != IDLE

Behaviour:
- Clock is clk. Reset is synchronous and active-high on reset. Reset forces state IDLE and clears every output and flags to 0. A reset mid-instruction discards the instruction with no writeback. instr_ready = 0 while reset is high.
- States: IDLE -> DECODE -> EXEC -> WB -> IDLE. All outputs are registered.
- IDLE: instr_ready = 1 and all control outputs = 0. On instr_valid & instr_ready, latch instr and go to DECODE.
- DECODE/EXEC/WB: op, exop, immediate, regOrImmed, Cin, buffAEnables and buffBEnables are held constant.
  - buffAEnables = 1<<rdest.
  - For R-type, buffBEnables = 1<<rsrc. For I-type, buffBEnables = 0.
- EXEC: alu_flags is captured into flags at the end of the cycle.
- WB: regEnables = 1<<rdest for exactly one cycle. It is not asserted for CMP, CMPI or illegal instructions.
- Latency: accept edge to WB is 3 cycles. Throughput is 1 instruction per 4 cycles. There is no back-to-back acceptance.
- R-type is op = 0000. exop decodes as:
  - 0101 ADD
  - 0111 ADDC (Cin = flags.C)
  - 1001 SUB (Cin = 1)
  - 1011 CMP (Cin = 1, no WB)
  - 0001 AND
  - 0010 OR
  - 0011 XOR
  - 1101 MOV
  - Any other exop is illegal.
- I-type ops:
  - 0101 ADDI
  - 1001 SUBI (Cin = 1)
  - 1011 CMPI (Cin = 1, no WB)
  - 0001 ANDI
  - 0010 ORI
  - 0011 XORI
  - 1101 MOVI
- I-type encoding:
  - imm8 = instr[7:0].
  - Sign-extend imm8 for ADDI/SUBI/CMPI/MOVI. Zero-extend for ANDI/ORI/XORI.
  - exop output = 0.
- Illegal instructions:
  - The instruction still walks DECODE/EXEC/WB.
  - All enables = 0 and flags are unchanged.
  - illegal pulses during DECODE.
- Cin is 0 unless stated above. immediate = 0 for R-type.
- instr_valid held high during a busy period is ignored. The producer must keep instr stable until the accepting cycle.

Decomposition:
- Shared package dp_ctrl_pkg contains:
  - opcode and exop localparams
  - state encoding (IDLE/DECODE/EXEC/WB)
  - flag bit indices
- One combinational sub-module, dp_instr_decode. Input: instr and flags.C. Outputs: op, exop, immediate, regOrImmed, Cin, is_rtype, no_wb, illegal.
- dp_sequencer keeps the FSM, instruction latch, flag register and one-hot expansion.

Test Plan:
- ADD R3,R5 (instr 0x0355) in IDLE -> DECODE: buffA = 0x0008, buffB = 0x0020, op = 0, exop = 5, regOrImmed = 0. WB (3rd cycle after accept): regEnables = 0x0008 for one cycle, then instr_ready = 1.
- ADDI R2,#-1 (0x52FF) -> immediate = 0xFFFF, regOrImmed = 1, buffB = 0, regEnables = 0x0004 in WB. ANDI R1,#0x80 (0x1180) -> immediate = 0x0080.
- CMP R1,R2 (0x01B2) with alu_flags = 5'b01010 -> Cin = 1, flags = 5'b01010 after EXEC, regEnables stays 0 throughout.
- flags.C = 1 then ADDC R4,R4 (0x0474) -> Cin = 1. With flags.C = 0 -> Cin = 0.
- Illegal 0xF000 -> illegal = 1 for one cycle, no enable asserted, flags unchanged, returns to IDLE after 4 cycles.
- reset = 1 during EXEC of 0x0355 -> next cycle all outputs 0, state IDLE, no regEnables pulse. instr_valid held high while busy -> exactly one instruction executed.
